// File: rtl/sipo_framer_if.sv
// Serial-in / parallel-out framer bus: serial input side, held-word handshake and status.
// The bit source / consumer uses the master modport; the framer uses the slave modport.
interface sipo_framer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             data_in;
    logic             shift_en;
    logic             frame_clr;
    logic             out_ack;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             overrun;

    modport master (
        output data_in, shift_en, frame_clr, out_ack,
        input  q, bit_cnt, data_out, out_valid, overrun
    );

    modport slave (
        input  data_in, shift_en, frame_clr, out_ack,
        output q, bit_cnt, data_out, out_valid, overrun
    );
endinterface

// File: rtl/sipo_framer.sv
// Serial-in parallel-out shift register with frame counting, a held output word
// with valid/ack handshake, and a sticky overrun flag when a pending word is overwritten.
module sipo_framer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    sipo_framer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_reg, q_next;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             out_valid_reg, out_valid_next;
    logic             overrun_reg, overrun_next;

    logic [WIDTH-1:0] q_shift;
    logic             last_bit;
    logic             complete;

    // Post-shift word: the new bit enters at the LSB end (MSB-first) or the MSB end (LSB-first).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign q_shift[gi] = bus.data_in;
                end else begin : g_mv
                    assign q_shift[gi] = q_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign q_shift[gi] = bus.data_in;
                end else begin : g_mv
                    assign q_shift[gi] = q_reg[gi+1];
                end
            end
        end
    endgenerate

    assign last_bit = (bit_cnt_reg == LAST_CNT);
    assign complete = bus.shift_en && !bus.frame_clr && last_bit;

    always_comb begin
        q_next         = q_reg;
        bit_cnt_next   = bit_cnt_reg;
        data_out_next  = data_out_reg;
        out_valid_next = out_valid_reg;
        overrun_next   = overrun_reg;

        if (bus.frame_clr) begin
            q_next       = '0;
            bit_cnt_next = '0;
        end else if (bus.shift_en) begin
            q_next       = q_shift;
            bit_cnt_next = last_bit ? '0 : bit_cnt_reg + CW'(1);
        end

        // Newest word always wins; completion beats a same-edge acknowledge.
        if (complete) begin
            data_out_next  = q_shift;
            out_valid_next = 1'b1;
        end else if (bus.out_ack) begin
            out_valid_next = 1'b0;
        end

        if (bus.frame_clr) begin
            overrun_next = 1'b0;
        end else if (complete && out_valid_reg && !bus.out_ack) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_reg         <= '0;
            bit_cnt_reg   <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            q_reg         <= q_next;
            bit_cnt_reg   <= bit_cnt_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bus.q         = q_reg;
    assign bus.bit_cnt   = bit_cnt_reg;
    assign bus.data_out  = data_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.overrun   = overrun_reg;
endmodule
